// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_muldiv_seq
//  Brief    : Iterative RV32M multiply/divide unit (shift-add multiply,
//             restoring divide) behind valid/ready handshakes.
//  Revision : 1.0  initial release
// ============================================================================
module alu_muldiv_seq #(
   parameter int N              = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [2:0]   op,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] result,
   output logic         zero,
   output logic         div_by_zero,
   output logic         overflow
);

   localparam int             c_ITERS    = N / BITS_PER_CYCLE;
   localparam int             c_CW       = $clog2(c_ITERS) + 1;
   localparam logic [c_CW-1:0] c_CNT_LOAD = c_CW'(c_ITERS - 1);
   localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
   localparam logic [N-1:0]   c_MIN_NEG  = {1'b1, {(N-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state, w_state_next;
   logic [2:0]        r_op;
   logic [N-1:0]      r_mcand;
   logic [N-1:0]      r_hi, r_lo;
   logic              r_neg_res, r_neg_rem;
   logic [c_CW-1:0]   r_count;

   logic              w_accept, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
   logic [N-1:0]      w_a_mag, w_b_mag, w_special_res;
   logic              w_div0, w_ovf, w_special;
   logic [N-1:0]      w_hi, w_lo, w_diff;
   logic [N:0]        w_sum, w_shift;
   logic [2*N-1:0]    w_prod_s;
   logic [N-1:0]      w_quo, w_rem, w_final;

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign w_accept  = in_valid & in_ready;

   // Signed operands are iterated on as magnitudes; signs are restored at the end.
   assign w_a_signed = (op == 3'b001) | (op == 3'b010) | (op == 3'b100) | (op == 3'b110);
   assign w_b_signed = (op == 3'b001) | (op == 3'b100) | (op == 3'b110);
   assign w_a_neg    = w_a_signed & a[N-1];
   assign w_b_neg    = w_b_signed & b[N-1];
   assign w_a_mag    = w_a_neg ? -a : a;
   assign w_b_mag    = w_b_neg ? -b : b;

   assign w_div0        = op[2] & (b == '0);
   assign w_ovf         = ((op == 3'b100) | (op == 3'b110)) & (a == c_MIN_NEG) & (b == '1);
   assign w_special     = w_div0 | w_ovf;
   assign w_special_res = w_div0 ? (op[1] ? a : '1) : (op[1] ? '0 : c_MIN_NEG);

   // BITS_PER_CYCLE unrolled steps; hi/lo hold product or remainder/quotient.
   always_comb begin
      w_hi    = r_hi;
      w_lo    = r_lo;
      w_sum   = '0;
      w_shift = '0;
      w_diff  = '0;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         if (!r_op[2]) begin
            w_sum = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_mcand} : '0);
            w_hi  = w_sum[N:1];
            w_lo  = {w_sum[0], w_lo[N-1:1]};
         end else begin
            w_shift = {w_hi, w_lo[N-1]};
            w_diff  = w_shift[N-1:0] - r_mcand;
            if (w_shift >= {1'b0, r_mcand}) begin
               w_hi = w_diff;
               w_lo = {w_lo[N-2:0], 1'b1};
            end else begin
               w_hi = w_shift[N-1:0];
               w_lo = {w_lo[N-2:0], 1'b0};
            end
         end
      end
   end

   assign w_prod_s = r_neg_res ? -{w_hi, w_lo} : {w_hi, w_lo};
   assign w_quo    = r_neg_res ? -w_lo : w_lo;
   assign w_rem    = r_neg_rem ? -w_hi : w_hi;

   always_comb begin
      w_final = '0;
      case (r_op)
         3'b000:                 w_final = w_prod_s[N-1:0];
         3'b001, 3'b010, 3'b011: w_final = w_prod_s[2*N-1:N];
         3'b100, 3'b101:         w_final = w_quo;
         default:                w_final = w_rem;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_next = w_special ? S_DONE : S_CALC;
         S_CALC:  if (r_count == '0) w_state_next = S_DONE;
         S_DONE:  if (out_ready) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op        <= '0;
         r_mcand     <= '0;
         r_hi        <= '0;
         r_lo        <= '0;
         r_neg_res   <= 1'b0;
         r_neg_rem   <= 1'b0;
         r_count     <= '0;
         result      <= '0;
         zero        <= 1'b0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
      end else if (w_accept) begin
         r_op        <= op;
         r_mcand     <= op[2] ? w_b_mag : w_a_mag;
         r_hi        <= '0;
         r_lo        <= op[2] ? w_a_mag : w_b_mag;
         r_neg_res   <= w_a_neg ^ w_b_neg;
         r_neg_rem   <= w_a_neg;
         r_count     <= c_CNT_LOAD;
         div_by_zero <= w_div0;
         overflow    <= w_ovf;
         if (w_special) begin
            result <= w_special_res;
            zero   <= (w_special_res == '0);
         end
      end else if (r_state == S_CALC) begin
         r_hi    <= w_hi;
         r_lo    <= w_lo;
         r_count <= r_count - c_CNT_ONE;
         if (r_count == '0) begin
            result <= w_final;
            zero   <= (w_final == '0);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_muldiv_seq
//  Brief    : Directed and randomised checks of alu_muldiv_seq (1 and 4 bits/cycle).
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_muldiv_seq;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_ready, out_valid, out_ready;
   logic [2:0]  op;
   logic [31:0] a, b, result;
   logic        zero, div_by_zero, overflow;
   logic        in_valid4, in_ready4, out_valid4, out_ready4;
   logic [31:0] result4;
   logic        zero4, div_by_zero4, overflow4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_muldiv_seq #(.N(32), .BITS_PER_CYCLE(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .div_by_zero(div_by_zero), .overflow(overflow)
   );

   alu_muldiv_seq #(.N(32), .BITS_PER_CYCLE(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
      .op(op), .a(a), .b(b), .out_valid(out_valid4), .out_ready(out_ready4),
      .result(result4), .zero(zero4), .div_by_zero(div_by_zero4), .overflow(overflow4)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Waits for out_valid, counting edges since acceptance (caller is 1 after the accept edge).
   task automatic wait_valid(output int lat, output logic rdy_low);
      lat = 1;
      rdy_low = 1'b1;
      while (!out_valid && lat < 200) begin
         if (in_ready) rdy_low = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp_res,
                         input logic exp_dz, input logic exp_ov, input int exp_lat);
      int   lat;
      logic rdy_low;
      op = o; a = x; b = y; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      op = ~o; a = ~x; b = ~y;
      wait_valid(lat, rdy_low);
      check({tag, "/out_valid"}, 64'(out_valid), 64'd1);
      if (exp_lat > 0) check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
      check({tag, "/in_ready_low"}, 64'(rdy_low), 64'd1);
      check({tag, "/result"}, 64'(result), 64'(exp_res));
      check({tag, "/zero"}, 64'(zero), 64'(exp_res == 32'd0));
      check({tag, "/div_by_zero"}, 64'(div_by_zero), 64'(exp_dz));
      check({tag, "/overflow"}, 64'(overflow), 64'(exp_ov));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "/in_ready_after"}, 64'(in_ready), 64'd1);
   endtask

   function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x,
                                         input logic [31:0] y);
      longint          sx = longint'($signed(x));
      longint          sy = longint'($signed(y));
      longint unsigned ux = {32'd0, x};
      longint unsigned uy = {32'd0, y};
      longint          p;
      longint unsigned up;
      logic            ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
      model = '0;
      case (o)
         3'd0: begin up = ux * uy; model = up[31:0]; end
         3'd1: begin p = sx * sy; model = p[63:32]; end
         3'd2: begin p = sx * longint'(uy); model = p[63:32]; end
         3'd3: begin up = ux * uy; model = up[63:32]; end
         3'd4: model = (y == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000
                                : 32'($signed(x) / $signed(y));
         3'd5: model = (y == 0) ? 32'hFFFF_FFFF : x / y;
         3'd6: model = (y == 0) ? x : ovf ? 32'd0 : 32'($signed(x) % $signed(y));
         default: model = (y == 0) ? x : x % y;
      endcase
   endfunction

   initial begin
      int          lat;
      logic        rdy_low;
      logic [31:0] x, y;
      int          sel;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_valid4 = 1'b0; out_ready4 = 1'b0;
      op = '0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset/in_ready", 64'(in_ready), 64'd1);
      check("reset/out_valid", 64'(out_valid), 64'd0);
      check("reset/result", 64'(result), 64'd0);
      check("reset/flags", {61'd0, zero, div_by_zero, overflow}, 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op("mul_neg",   3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 1'b0, 33);
      run_op("mulh_min",  3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 1'b0, 33);
      run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0, 33);
      run_op("mulhsu",    3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 1'b0, 1'b0, 33);
      run_op("div_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1, 1);
      run_op("rem_ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0, 1'b1, 1);
      run_op("divu_by0",  3'd5, 32'h100,       32'd0,         32'hFFFF_FFFF, 1'b1, 1'b0, 1);
      run_op("remu_by0",  3'd7, 32'h100,       32'd0,         32'h100,       1'b1, 1'b0, 1);
      run_op("rem_neg",   3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, 1'b0, 33);
      run_op("div_neg",   3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, 1'b0, 33);
      run_op("rem_zero",  3'd6, 32'd6,         32'd3,         32'd0,         1'b0, 1'b0, 33);

      // Result held under back-pressure while a second op waits on in_valid.
      op = 3'd3; a = 32'h1234_5678; b = 32'h10; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_valid(lat, rdy_low);
      check("b2b/lat1", 64'(lat), 64'd33);
      check("b2b/res1", 64'(result), 64'd1);
      op = 3'd5; a = 32'h100; b = 32'd7; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("b2b/hold_valid", 64'(out_valid), 64'd1);
         check("b2b/hold_result", {31'd0, zero, result}, 64'd1);
         check("b2b/hold_in_ready", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("b2b/handoff_ready", 64'(in_ready), 64'd1);
      check("b2b/handoff_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("b2b/accepted", 64'(in_ready), 64'd0);
      wait_valid(lat, rdy_low);
      check("b2b/lat2", 64'(lat), 64'd33);
      check("b2b/res2", 64'(result), 64'h24);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;

      // Four bits per cycle.
      op = 3'd0; a = 32'd7; b = 32'hFFFF_FFFD; in_valid4 = 1'b1;
      @(posedge clk); #1;
      in_valid4 = 1'b0;
      lat = 1;
      while (!out_valid4 && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      check("bpc4/latency", 64'(lat), 64'd9);
      check("bpc4/result", 64'(result4), 64'hFFFF_FFEB);
      check("bpc4/zero", 64'(zero4), 64'd0);
      out_ready4 = 1'b1;
      @(posedge clk); #1;
      out_ready4 = 1'b0;
      check("bpc4/in_ready", 64'(in_ready4), 64'd1);

      // Asynchronous reset in the middle of CALC.
      op = 3'd0; a = 32'd5; b = 32'd9; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("areset/in_ready", 64'(in_ready), 64'd1);
      check("areset/out_valid", 64'(out_valid), 64'd0);
      check("areset/result", 64'(result), 64'd0);
      check("areset/flags", {61'd0, zero, div_by_zero, overflow}, 64'd0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      check("areset/no_result", 64'(out_valid), 64'd0);
      run_op("after_reset", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 1'b0, 33);

      // Randomised sweep over every op code, biased toward corner operands.
      for (int o = 0; o < 8; o++) begin
         for (int k = 0; k < 25; k++) begin
            x   = $urandom;
            y   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) y = 32'd0;
            if (sel == 1) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
            if (sel == 2) y = $urandom_range(1, 15);
            if (sel == 3) x = $urandom_range(0, 3);
            run_op($sformatf("rand_op%0d", o), 3'(o), x, y, model(3'(o), x, y),
                   (o >= 4) && (y == 32'd0),
                   ((o == 4) || (o == 6)) && (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF),
                   0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
